// File: rtl/sec_zone_controller.sv
// Four-zone security controller: alert latching, round-robin guard dispatch,
// emergency output sequencing with hold timers, and the access-code door FSM.
module sec_zone_controller #(
    parameter logic [11:0] CODE        = 12'd123,
    parameter int          MAX_TRIES   = 3,
    parameter int          LOCK_CYCLES = 16,
    parameter int          DOOR_CYCLES = 4,
    parameter int          ALARM_HOLD  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fire,
    input  logic        earth_quake,
    input  logic [3:0]  mds_evt,
    input  logic [3:0]  cam_evt,
    input  logic        code_valid,
    input  logic [11:0] access_code,
    input  logic        guard_ack,
    output logic [3:0]  sec,
    output logic        dispatch_valid,
    output logic [3:0]  pending,
    output logic        door,
    output logic        lockout,
    output logic        fire_alarm,
    output logic        fire_exit,
    output logic        fire_dept_alert,
    output logic        server_backup_signal
);

    localparam int HOLD_W = $clog2(ALARM_HOLD + 1);
    localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} arb_state_t;
    typedef enum logic [1:0] {ACC_READY = 2'd0, ACC_OPEN = 2'd1, ACC_LOCKED = 2'd2} acc_state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] z);
        onehot4 = 4'b0001 << z;
    endfunction

    // Lowest rotational offset from ptr wins, so scan offsets from far to near.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] fire_cnt_r;
    logic              emg_s;
    logic              fire_seen_s;
    arb_state_t        arb_state_r;
    logic [1:0]        rr_ptr_r;
    logic [1:0]        zone_r;
    logic [1:0]        pick_s;
    logic [3:0]        clr_mask_s;
    acc_state_t        acc_state_r;
    logic [DOOR_W-1:0] door_cnt_r;
    logic [LOCK_W-1:0] lock_cnt_r;
    logic [2:0]        tries_r;
    logic              code_ok_s;
    logic              open_next_s;

    // Combinational emergency status, arbitration pick and ack-driven clear mask.
    always_comb begin
        emg_s       = fire | earth_quake | (hold_cnt_r != {HOLD_W{1'b0}});
        fire_seen_s = fire | (fire_cnt_r != {HOLD_W{1'b0}});
        pick_s      = rr_pick(pending, rr_ptr_r);
        code_ok_s   = (access_code == CODE);
        if ((arb_state_r == ARB_GRANT) && guard_ack && !emg_s) begin
            clr_mask_s = onehot4(zone_r);
        end else begin
            clr_mask_s = 4'd0;
        end
        if ((acc_state_r == ACC_READY) && code_valid && code_ok_s) begin
            open_next_s = 1'b1;
        end else if ((acc_state_r == ACC_OPEN) && (door_cnt_r > DOOR_W'(1))) begin
            open_next_s = 1'b1;
        end else begin
            open_next_s = 1'b0;
        end
    end

    // Emergency hold timers and registered alarm/door outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r           <= {HOLD_W{1'b0}};
            fire_cnt_r           <= {HOLD_W{1'b0}};
            fire_alarm           <= 1'b0;
            fire_exit            <= 1'b0;
            server_backup_signal <= 1'b0;
            fire_dept_alert      <= 1'b0;
            door                 <= 1'b0;
        end else begin
            if (fire | earth_quake) begin
                hold_cnt_r <= HOLD_W'(ALARM_HOLD);
            end else if (hold_cnt_r != {HOLD_W{1'b0}}) begin
                hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
            end
            if (fire) begin
                fire_cnt_r <= HOLD_W'(ALARM_HOLD);
            end else if (fire_cnt_r != {HOLD_W{1'b0}}) begin
                fire_cnt_r <= fire_cnt_r - HOLD_W'(1);
            end
            fire_alarm           <= emg_s;
            fire_exit            <= emg_s;
            server_backup_signal <= emg_s;
            fire_dept_alert      <= fire_seen_s;
            door                 <= emg_s | open_next_s;
        end
    end

    // Alert latch: new events are OR-ed in after the clear, so set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 4'd0;
        end else begin
            pending <= (pending & ~clr_mask_s) | mds_evt | cam_evt;
        end
    end

    // Guard-dispatch arbiter; an emergency aborts any grant without clearing the alert.
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_state_r    <= ARB_IDLE;
            rr_ptr_r       <= 2'd0;
            zone_r         <= 2'd0;
            sec            <= 4'd0;
            dispatch_valid <= 1'b0;
        end else begin
            case (arb_state_r)
                ARB_IDLE: begin
                    if (!emg_s && (pending != 4'd0)) begin
                        zone_r         <= pick_s;
                        sec            <= onehot4(pick_s);
                        dispatch_valid <= 1'b1;
                        arb_state_r    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (emg_s) begin
                        sec            <= 4'd0;
                        dispatch_valid <= 1'b0;
                        arb_state_r    <= ARB_IDLE;
                    end else if (guard_ack) begin
                        rr_ptr_r       <= zone_r + 2'd1;
                        sec            <= 4'd0;
                        dispatch_valid <= 1'b0;
                        arb_state_r    <= ARB_IDLE;
                    end
                end
                default: begin
                    sec            <= 4'd0;
                    dispatch_valid <= 1'b0;
                    arb_state_r    <= ARB_IDLE;
                end
            endcase
        end
    end

    // Access-code FSM with retry counting and timed lockout.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_state_r <= ACC_READY;
            door_cnt_r  <= {DOOR_W{1'b0}};
            lock_cnt_r  <= {LOCK_W{1'b0}};
            tries_r     <= 3'd0;
            lockout     <= 1'b0;
        end else begin
            case (acc_state_r)
                ACC_READY: begin
                    if (code_valid) begin
                        if (code_ok_s) begin
                            acc_state_r <= ACC_OPEN;
                            door_cnt_r  <= DOOR_W'(DOOR_CYCLES);
                            tries_r     <= 3'd0;
                        end else if ((tries_r + 3'd1) == 3'(MAX_TRIES)) begin
                            acc_state_r <= ACC_LOCKED;
                            lock_cnt_r  <= LOCK_W'(LOCK_CYCLES);
                            tries_r     <= 3'd0;
                            lockout     <= 1'b1;
                        end else begin
                            tries_r <= tries_r + 3'd1;
                        end
                    end
                end
                ACC_OPEN: begin
                    if (door_cnt_r <= DOOR_W'(1)) begin
                        acc_state_r <= ACC_READY;
                        door_cnt_r  <= {DOOR_W{1'b0}};
                    end else begin
                        door_cnt_r <= door_cnt_r - DOOR_W'(1);
                    end
                end
                ACC_LOCKED: begin
                    if (lock_cnt_r <= LOCK_W'(1)) begin
                        acc_state_r <= ACC_READY;
                        lock_cnt_r  <= {LOCK_W{1'b0}};
                        lockout     <= 1'b0;
                    end else begin
                        lock_cnt_r <= lock_cnt_r - LOCK_W'(1);
                    end
                end
                default: begin
                    acc_state_r <= ACC_READY;
                    lockout     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sec_zone_controller.sv
// Bench for sec_zone_controller: constant vector table, directed corner sequences
// and randomized traffic against a timestamp-based reference model.
module tb_sec_zone_controller;

    localparam int AH = 8;
    localparam int DC = 4;
    localparam int LC = 16;
    localparam int MT = 3;

    logic        clk = 1'b0;
    logic        rst, fire, earth_quake, code_valid, guard_ack;
    logic [3:0]  mds_evt, cam_evt;
    logic [11:0] access_code;
    logic [3:0]  sec, pending;
    logic        dispatch_valid, door, lockout, fire_alarm, fire_exit;
    logic        fire_dept_alert, server_backup_signal;

    int compared;
    int mismatched;

    // reference model state
    int         cyc;
    int         last_any, last_fire, open_last, lock_last, tries;
    int         m_gz, m_ptr;
    logic [3:0] m_pend, m_sec;
    logic       m_dv, m_door, m_lock, m_fa, m_fd;

    logic [3:0] got[$];
    logic [3:0] pend_q[$];

    typedef struct {
        logic        f;
        logic        q;
        logic [3:0]  m;
        logic        cv;
        logic [11:0] c;
        logic [3:0]  e_sec;
        logic [3:0]  e_pend;
        logic        e_door;
        logic        e_lock;
        logic        e_fa;
        logic        e_fd;
    } vec_t;
    vec_t tbl[18];

    sec_zone_controller dut (
        .clk(clk), .rst(rst), .fire(fire), .earth_quake(earth_quake),
        .mds_evt(mds_evt), .cam_evt(cam_evt), .code_valid(code_valid),
        .access_code(access_code), .guard_ack(guard_ack), .sec(sec),
        .dispatch_valid(dispatch_valid), .pending(pending), .door(door),
        .lockout(lockout), .fire_alarm(fire_alarm), .fire_exit(fire_exit),
        .fire_dept_alert(fire_dept_alert), .server_backup_signal(server_backup_signal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(logic f, logic q, logic [3:0] m, logic cv, logic [11:0] c,
                                 logic [3:0] es, logic [3:0] ep, logic ed, logic el,
                                 logic efa, logic efd);
        vec_t v;
        v.f = f; v.q = q; v.m = m; v.cv = cv; v.c = c;
        v.e_sec = es; v.e_pend = ep; v.e_door = ed; v.e_lock = el; v.e_fa = efa; v.e_fd = efd;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic       emg, fseen, busy;
        logic [3:0] old;
        int         clr;
        if (rst) begin
            last_any = -1000000; last_fire = -1000000;
            open_last = -1000000; lock_last = -1000000;
            tries = 0; m_gz = -1; m_ptr = 0; m_pend = 4'd0;
            m_sec = 4'd0; m_dv = 1'b0; m_door = 1'b0; m_lock = 1'b0; m_fa = 1'b0; m_fd = 1'b0;
        end else begin
            if (fire || earth_quake) last_any = cyc;
            if (fire) last_fire = cyc;
            emg   = (cyc - last_any) <= AH;
            fseen = (cyc - last_fire) <= AH;
            old = m_pend;
            clr = -1;
            if (m_gz >= 0) begin
                if (emg) m_gz = -1;
                else if (guard_ack) begin
                    clr = m_gz; m_ptr = (m_gz + 1) % 4; m_gz = -1;
                end
            end else if (!emg && old != 4'd0) begin
                for (int k = 0; k < 4; k++)
                    if (m_gz < 0 && old[(m_ptr + k) % 4]) m_gz = (m_ptr + k) % 4;
            end
            m_pend = old;
            if (clr >= 0) m_pend[clr] = 1'b0;
            m_pend = m_pend | mds_evt | cam_evt;
            busy = (cyc - 1 <= open_last) || (cyc - 1 <= lock_last);
            if (!busy && code_valid) begin
                if (access_code == 12'd123) begin
                    open_last = cyc + DC - 1; tries = 0;
                end else begin
                    tries++;
                    if (tries == MT) begin lock_last = cyc + LC - 1; tries = 0; end
                end
            end
            m_sec  = (m_gz >= 0) ? 4'(1 << m_gz) : 4'd0;
            m_dv   = (m_gz >= 0);
            m_door = emg || (cyc <= open_last);
            m_lock = (cyc <= lock_last);
            m_fa   = emg;
            m_fd   = fseen;
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("sec", sec, m_sec);
        chk("dispatch_valid", dispatch_valid, m_dv);
        chk("pending", pending, m_pend);
        chk("door", door, m_door);
        chk("lockout", lockout, m_lock);
        chk("fire_alarm", fire_alarm, m_fa);
        chk("fire_exit", fire_exit, m_fa);
        chk("fire_dept_alert", fire_dept_alert, m_fd);
        chk("server_backup", server_backup_signal, m_fa);
    endtask

    task automatic clear_inputs();
        fire = 1'b0; earth_quake = 1'b0; mds_evt = 4'd0; cam_evt = 4'd0;
        code_valid = 1'b0; access_code = 12'd0; guard_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic run_grants(input int max_cyc, input logic pulse2);
        int   age;
        logic pulsed;
        age = 0; pulsed = 1'b0;
        got.delete(); pend_q.delete();
        for (int k = 0; k < max_cyc; k++) begin
            tick();
            cam_evt = 4'd0;
            guard_ack = 1'b0;
            if (m_dv) begin
                if (age == 0) begin got.push_back(sec); pend_q.push_back(pending); end
                age++;
            end else age = 0;
            if (m_dv && age == 2) begin
                guard_ack = 1'b1;
                if (pulse2 && m_sec == 4'b0100 && !pulsed) begin
                    cam_evt = 4'b0100; pulsed = 1'b1;
                end
            end
        end
        guard_ack = 1'b0;
    endtask

    initial begin
        int   cnt;
        logic door_seen;
        compared = 0; mismatched = 0; cyc = 0;
        clear_inputs();
        rst = 1'b1;

        // reset then idle
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_outputs", {sec, dispatch_valid, pending, door, lockout, fire_alarm,
                                 fire_exit, fire_dept_alert, server_backup_signal}, 0);
        end

        // constant vector table
        tbl[0]  = mkv(0, 0, 4'd0, 0, 12'd0,   4'd0, 4'd0, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 1, 4'd0, 0, 12'd0,   4'd0, 4'd0, 1, 0, 1, 0);
        for (int i = 2; i <= 9; i++)
            tbl[i] = mkv(0, 0, 4'd0, 0, 12'd0, 4'd0, 4'd0, 1, 0, 1, 0);
        tbl[10] = mkv(0, 0, 4'd0, 0, 12'd0,   4'd0, 4'd0, 0, 0, 0, 0);
        tbl[11] = mkv(0, 0, 4'd0, 1, 12'd123, 4'd0, 4'd0, 1, 0, 0, 0);
        for (int i = 12; i <= 14; i++)
            tbl[i] = mkv(0, 0, 4'd0, 0, 12'd0, 4'd0, 4'd0, 1, 0, 0, 0);
        tbl[15] = mkv(0, 0, 4'd0, 0, 12'd0,   4'd0, 4'd0, 0, 0, 0, 0);
        tbl[16] = mkv(1, 0, 4'd0, 0, 12'd0,   4'd0, 4'd0, 1, 0, 1, 1);
        tbl[17] = mkv(0, 0, 4'b0100, 0, 12'd0, 4'd0, 4'b0100, 1, 0, 1, 1);
        do_reset();
        for (int i = 0; i < 18; i++) begin
            fire = tbl[i].f; earth_quake = tbl[i].q; mds_evt = tbl[i].m;
            code_valid = tbl[i].cv; access_code = tbl[i].c;
            tick();
            chk($sformatf("tbl%0d_sec", i), sec, tbl[i].e_sec);
            chk($sformatf("tbl%0d_pending", i), pending, tbl[i].e_pend);
            chk($sformatf("tbl%0d_door", i), door, tbl[i].e_door);
            chk($sformatf("tbl%0d_lockout", i), lockout, tbl[i].e_lock);
            chk($sformatf("tbl%0d_fire_alarm", i), fire_alarm, tbl[i].e_fa);
            chk($sformatf("tbl%0d_fire_dept", i), fire_dept_alert, tbl[i].e_fd);
        end

        // round robin
        do_reset();
        mds_evt = 4'b1010; cam_evt = 4'b0001;
        tick();
        mds_evt = 4'd0; cam_evt = 4'd0;
        run_grants(30, 1'b0);
        chk("rr_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("rr_g0", got[0], 4'b0001); chk("rr_g1", got[1], 4'b0010); chk("rr_g2", got[2], 4'b1000);
            chk("rr_p0", pend_q[0], 4'b1011); chk("rr_p1", pend_q[1], 4'b1010); chk("rr_p2", pend_q[2], 4'b1000);
        end
        chk("rr_final_pending", pending, 4'd0);

        // set wins on ack of zone2
        do_reset();
        mds_evt = 4'b0111;
        tick();
        mds_evt = 4'd0;
        run_grants(40, 1'b1);
        chk("sw_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("sw_g2", got[2], 4'b0100); chk("sw_g3", got[3], 4'b0100);
            chk("sw_p3", pend_q[3], 4'b0100);
        end
        chk("sw_final_pending", pending, 4'd0);

        // emergency preempt, ack in abort cycle ignored
        do_reset();
        mds_evt = 4'b0010;
        tick();
        mds_evt = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (m_dv) break;
            tick();
        end
        chk("emg_pre_dv", dispatch_valid, 1);
        chk("emg_pre_sec", sec, 4'b0010);
        fire = 1'b1; guard_ack = 1'b1;
        tick();
        guard_ack = 1'b0;
        chk("emg_abort", {sec, dispatch_valid}, 0);
        chk("emg_outs", {fire_alarm, fire_exit, fire_dept_alert, server_backup_signal, door}, 5'b11111);
        chk("emg_pending_kept", pending, 4'b0010);
        tick(); tick();
        fire = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (fire_alarm) cnt++;
            else break;
        end
        chk("emg_hold_len", cnt, 8);
        chk("emg_regrant", sec, 4'b0010);

        // reset mid-handshake
        mds_evt = 4'b1111;
        tick();
        mds_evt = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (m_dv) break;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst", {sec, dispatch_valid, pending}, 0);
        tick();
        chk("midrst_idle", {sec, dispatch_valid, pending}, 0);

        // access lockout then good code
        do_reset();
        for (int i = 0; i < 3; i++) begin
            code_valid = 1'b1; access_code = 12'd294;
            tick();
        end
        code_valid = 1'b0;
        chk("lock_start", lockout, 1);
        cnt = 1; door_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            code_valid = (k == 3); access_code = 12'd123;
            tick();
            code_valid = 1'b0;
            door_seen = door_seen | door;
            if (lockout) cnt++;
            else break;
        end
        chk("lock_len", cnt, 16);
        chk("lock_door_ignored", door_seen, 0);
        code_valid = 1'b1; access_code = 12'd123;
        tick();
        code_valid = 1'b0;
        cnt = door ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (door) cnt++;
            else break;
        end
        chk("door_len", cnt, 4);

        // randomized traffic
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst         = ($urandom_range(0, 499) == 0);
            fire        = ($urandom_range(0, 99) < 2);
            earth_quake = ($urandom_range(0, 99) < 1);
            mds_evt     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
            cam_evt     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
            guard_ack   = ($urandom_range(0, 2) == 0);
            code_valid  = ($urandom_range(0, 7) == 0);
            access_code = ($urandom_range(0, 1) == 0) ? 12'd123 : 12'($urandom);
            tick();
        end
        clear_inputs();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
